// File: rtl/imem_boot_loader_if.sv
// Byte-stream input and instruction-memory write port of the boot loader.
// The loader uses the slave side. The master side is the stream source and memory.
interface imem_boot_loader_if #(
  parameter int ADDR_WIDTH = 10
);
  logic [7:0]            in_data;
  logic                  in_valid;
  logic                  in_ready;
  logic                  mem_wr_en;
  logic [ADDR_WIDTH-1:0] mem_wr_addr;
  logic [31:0]           mem_wr_data;

  modport master (
    output in_data, in_valid,
    input  in_ready, mem_wr_en, mem_wr_addr, mem_wr_data
  );

  modport slave (
    input  in_data, in_valid,
    output in_ready, mem_wr_en, mem_wr_addr, mem_wr_data
  );
endinterface

// File: rtl/imem_boot_loader.sv
// Loads a length-prefixed, XOR-checksummed byte image into instruction memory.
// The CPU is held in reset until the checksum has been verified.
module imem_boot_loader #(
  parameter int ADDR_WIDTH = 10,
  parameter int MAX_WORDS  = 1024,
  parameter int BASE_WORD  = 0
) (
  input  logic                clk,
  input  logic                reset,
  imem_boot_loader_if.slave   bus,
  output logic                cpu_reset,
  output logic                done,
  output logic                error,
  output logic [15:0]         word_count
);

  typedef enum logic [2:0] {HDR_HI, HDR_LO, DATA, CSUM, RUN, ERR} state_t;

  localparam logic [16:0]           MAX_W  = 17'(MAX_WORDS);
  localparam logic [ADDR_WIDTH-1:0] BASE_A = ADDR_WIDTH'(BASE_WORD);

  state_t                state_q, state_d;
  logic [7:0]            hdr_hi_q, hdr_hi_d;
  logic [15:0]           count_q, count_d;
  logic [31:0]           asm_q, asm_d;
  logic [1:0]            lane_q, lane_d;
  logic [7:0]            xor_q, xor_d;
  logic                  wr_en_q, wr_en_d;
  logic [ADDR_WIDTH-1:0] wr_addr_q, wr_addr_d;
  logic [31:0]           wr_data_q, wr_data_d;
  logic [15:0]           word_count_q, word_count_d;
  logic                  cpu_reset_q, cpu_reset_d;
  logic                  done_q, done_d;
  logic                  error_q, error_d;
  logic                  in_ready;
  logic                  xfer;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= HDR_HI;
      hdr_hi_q     <= 8'd0;
      count_q      <= 16'd0;
      asm_q        <= 32'd0;
      lane_q       <= 2'd0;
      xor_q        <= 8'd0;
      wr_en_q      <= 1'b0;
      wr_addr_q    <= BASE_A;
      wr_data_q    <= 32'd0;
      word_count_q <= 16'd0;
      cpu_reset_q  <= 1'b1;
      done_q       <= 1'b0;
      error_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      hdr_hi_q     <= hdr_hi_d;
      count_q      <= count_d;
      asm_q        <= asm_d;
      lane_q       <= lane_d;
      xor_q        <= xor_d;
      wr_en_q      <= wr_en_d;
      wr_addr_q    <= wr_addr_d;
      wr_data_q    <= wr_data_d;
      word_count_q <= word_count_d;
      cpu_reset_q  <= cpu_reset_d;
      done_q       <= done_d;
      error_q      <= error_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    hdr_hi_d     = hdr_hi_q;
    count_d      = count_q;
    asm_d        = asm_q;
    lane_d       = lane_q;
    xor_d        = xor_q;
    wr_en_d      = 1'b0;
    wr_addr_d    = wr_addr_q;
    wr_data_d    = wr_data_q;
    word_count_d = word_count_q;
    cpu_reset_d  = cpu_reset_q;
    done_d       = done_q;
    error_d      = error_q;
    in_ready     = (state_q == HDR_HI) || (state_q == HDR_LO) ||
                   (state_q == DATA)   || (state_q == CSUM);
    xfer         = bus.in_valid && in_ready;

    case (state_q)
      HDR_HI: begin
        if (xfer) begin
          hdr_hi_d = bus.in_data;
          state_d  = HDR_LO;
        end
      end
      HDR_LO: begin
        if (xfer) begin
          count_d = {hdr_hi_q, bus.in_data};
          if ({1'b0, hdr_hi_q, bus.in_data} > MAX_W) begin
            state_d = ERR;
            error_d = 1'b1;
          end else if (count_d == 16'd0) begin
            state_d = CSUM;
          end else begin
            state_d = DATA;
          end
        end
      end
      DATA: begin
        if (xfer) begin
          asm_d  = {asm_q[23:0], bus.in_data};
          xor_d  = xor_q ^ bus.in_data;
          lane_d = lane_q + 2'd1;
          // Fourth byte: the strobe is registered, so the next word's first
          // byte can be taken in the same cycle the write goes out.
          if (lane_q == 2'd3) begin
            wr_en_d      = 1'b1;
            wr_data_d    = asm_d;
            wr_addr_d    = BASE_A + ADDR_WIDTH'(word_count_q);
            word_count_d = word_count_q + 16'd1;
            if (word_count_d == count_q) begin
              state_d = CSUM;
            end
          end
        end
      end
      CSUM: begin
        if (xfer) begin
          if (bus.in_data == xor_q) begin
            state_d     = RUN;
            done_d      = 1'b1;
            cpu_reset_d = 1'b0;
          end else begin
            state_d = ERR;
            error_d = 1'b1;
          end
        end
      end
      RUN:     state_d = RUN;
      ERR:     state_d = ERR;
      default: state_d = HDR_HI;
    endcase
  end

  assign bus.in_ready    = in_ready;
  assign bus.mem_wr_en   = wr_en_q;
  assign bus.mem_wr_addr = wr_addr_q;
  assign bus.mem_wr_data = wr_data_q;
  assign cpu_reset       = cpu_reset_q;
  assign done            = done_q;
  assign error           = error_q;
  assign word_count      = word_count_q;

endmodule
